// File: rtl/cog_ram_dp.sv
// ---------------------------------------------------------------------------
// cog_ram_dp
//
// Purpose:
//    Parametrised single-clock true dual-port cog RAM. Port A serves the cog
//    ALU/fetch path, port B the hub/debug loader. Both ports can read and
//    byte-write independently in every cycle. After reset a clear sequencer
//    zeroes the whole array, one word per cycle, before user accesses are
//    accepted.
//
// Parameters:
//    DW           data width in bits (multiple of 8)
//    AW           address width, depth = 2**AW words
//    RDW_NEW      read-during-write result: 0 = old word, 1 = merged new word
//                 (applies to the writing port and to the other port)
//    CLR_ON_RESET 1 = clear the array after reset, 0 = no clear, busy stays 0
//
// Ports:
//    clk                 single clock, rising edge
//    res                 asynchronous active-high reset
//    a_ena/b_ena         port access enable
//    a_w/b_w             write (qualified by ena)
//    a_be/b_be           byte enables for writes
//    a_addr/b_addr       word address
//    a_d/b_d             write data
//    a_q/b_q             registered read data (1 cycle latency)
//    busy                clear sequencer active, port accesses ignored
//    wcol                one-cycle pulse after both ports wrote overlapping
//                        bytes of the same word
//
// Optional feature (macro COG_RAM_DP_PARITY_EN):
//    Each byte lane carries one even-parity bit. Adds inputs/outputs
//    inj_perr (invert stored parity of every byte written this cycle),
//    a_perr and b_perr (registered with q, 1 if any read byte fails parity).
// ---------------------------------------------------------------------------
module cog_ram_dp #(
   parameter int DW           = 32,
   parameter int AW           = 9,
   parameter int RDW_NEW      = 0,
   parameter int CLR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              res,
   input  logic              a_ena,
   input  logic              a_w,
   input  logic [DW/8-1:0]   a_be,
   input  logic [AW-1:0]     a_addr,
   input  logic [DW-1:0]     a_d,
   output logic [DW-1:0]     a_q,
   input  logic              b_ena,
   input  logic              b_w,
   input  logic [DW/8-1:0]   b_be,
   input  logic [AW-1:0]     b_addr,
   input  logic [DW-1:0]     b_d,
   output logic [DW-1:0]     b_q,
`ifdef COG_RAM_DP_PARITY_EN
   input  logic              inj_perr,
   output logic              a_perr,
   output logic              b_perr,
`endif
   output logic              busy,
   output logic              wcol
);

   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

   // Storage. Not reset: the clear sequencer is what gives it a known value.
   logic [DW-1:0] mem [DEPTH];
`ifdef COG_RAM_DP_PARITY_EN
   logic [NB-1:0] mem_par [DEPTH];
`endif

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          busy_int;

   logic          a_acc, b_acc;
   logic          a_we, b_we;
   logic          same_addr;
   logic [NB-1:0] a_wmask, b_wmask;

   logic [DW-1:0] a_old, b_old;
   logic [DW-1:0] a_new, b_new;
   logic [DW-1:0] a_rd, b_rd;

   logic [DW-1:0] a_dout_q, a_dout_d;
   logic [DW-1:0] b_dout_q, b_dout_d;
   logic          wcol_q, wcol_d;

`ifdef COG_RAM_DP_PARITY_EN
   logic [NB-1:0] a_old_par, b_old_par;
   logic [NB-1:0] a_new_par, b_new_par;
   logic [NB-1:0] a_rd_par, b_rd_par;
   logic [NB-1:0] a_wpar, b_wpar;
   logic          a_perr_q, a_perr_d;
   logic          b_perr_q, b_perr_d;
`endif

   // Even parity per byte lane: the stored bit equals the XOR of the byte.
   function automatic logic [NB-1:0] byte_par(input logic [DW-1:0] d);
      logic [NB-1:0] p;
      p = '0;
      for (int i = 0; i < NB; i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction

   // Clear sequencer: walks cnt over every address while in CLEAR and drops
   // to IDLE right after the last address has been written.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Sequencer state. Reset restarts the clear from address 0.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_int = (state_q == ST_CLEAR);
   assign busy     = busy_int;

   // Access qualification. While the clear runs both ports are masked.
   // On a same-word collision port A owns every byte it enables, so port B's
   // write mask drops those lanes; the two masks never overlap on one word.
   always_comb begin
      a_acc     = a_ena & ~busy_int;
      b_acc     = b_ena & ~busy_int;
      a_we      = a_acc & a_w;
      b_we      = b_acc & b_w;
      same_addr = (a_addr == b_addr);
      a_wmask   = {NB{a_we}} & a_be;
      b_wmask   = {NB{b_we}} & b_be & ~({NB{same_addr}} & a_wmask);
   end

   assign a_old = mem[a_addr];
   assign b_old = mem[b_addr];

   // Post-write view of each port's word, including bytes landed by the other
   // port when both address the same word. Used only when RDW_NEW selects
   // new-data read-during-write behaviour.
   always_comb begin
      a_new = a_old;
      b_new = b_old;
      for (int i = 0; i < NB; i++) begin
         if (a_wmask[i]) begin
            a_new[8*i +: 8] = a_d[8*i +: 8];
         end else if (b_wmask[i] && same_addr) begin
            a_new[8*i +: 8] = b_d[8*i +: 8];
         end
         if (b_wmask[i]) begin
            b_new[8*i +: 8] = b_d[8*i +: 8];
         end else if (a_wmask[i] && same_addr) begin
            b_new[8*i +: 8] = a_d[8*i +: 8];
         end
      end
   end

   assign a_rd = (RDW_NEW != 0) ? a_new : a_old;
   assign b_rd = (RDW_NEW != 0) ? b_new : b_old;

`ifdef COG_RAM_DP_PARITY_EN
   assign a_old_par = mem_par[a_addr];
   assign b_old_par = mem_par[b_addr];
   assign a_wpar    = byte_par(a_d) ^ {NB{inj_perr}};
   assign b_wpar    = byte_par(b_d) ^ {NB{inj_perr}};

   // Parity lanes follow exactly the same merge rules as the data lanes.
   always_comb begin
      a_new_par = a_old_par;
      b_new_par = b_old_par;
      for (int i = 0; i < NB; i++) begin
         if (a_wmask[i]) begin
            a_new_par[i] = a_wpar[i];
         end else if (b_wmask[i] && same_addr) begin
            a_new_par[i] = b_wpar[i];
         end
         if (b_wmask[i]) begin
            b_new_par[i] = b_wpar[i];
         end else if (a_wmask[i] && same_addr) begin
            b_new_par[i] = a_wpar[i];
         end
      end
   end

   assign a_rd_par = (RDW_NEW != 0) ? a_new_par : a_old_par;
   assign b_rd_par = (RDW_NEW != 0) ? b_new_par : b_old_par;
`endif

   // Array write port. The clear owns the array while busy; otherwise each
   // port lands its own byte lanes (collision lanes already resolved).
   always_ff @(posedge clk) begin
      if (busy_int) begin
         mem[cnt_q] <= '0;
`ifdef COG_RAM_DP_PARITY_EN
         mem_par[cnt_q] <= '0;
`endif
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (a_wmask[i]) begin
               mem[a_addr][8*i +: 8] <= a_d[8*i +: 8];
`ifdef COG_RAM_DP_PARITY_EN
               mem_par[a_addr][i] <= a_wpar[i];
`endif
            end
            if (b_wmask[i]) begin
               mem[b_addr][8*i +: 8] <= b_d[8*i +: 8];
`ifdef COG_RAM_DP_PARITY_EN
               mem_par[b_addr][i] <= b_wpar[i];
`endif
            end
         end
      end
   end

   // Next read data and collision flag. Outputs are forced to zero while the
   // clear runs; an idle port holds its last read value.
   always_comb begin
      a_dout_d = a_dout_q;
      b_dout_d = b_dout_q;
      wcol_d   = 1'b0;
      if (busy_int) begin
         a_dout_d = '0;
         b_dout_d = '0;
      end else begin
         if (a_acc) begin
            a_dout_d = a_rd;
         end
         if (b_acc) begin
            b_dout_d = b_rd;
         end
         wcol_d = a_we & b_we & same_addr & (|(a_be & b_be));
      end
   end

   // Registered port outputs.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         a_dout_q <= '0;
         b_dout_q <= '0;
         wcol_q   <= 1'b0;
      end else begin
         a_dout_q <= a_dout_d;
         b_dout_q <= b_dout_d;
         wcol_q   <= wcol_d;
      end
   end

   assign a_q  = a_dout_q;
   assign b_q  = b_dout_q;
   assign wcol = wcol_q;

`ifdef COG_RAM_DP_PARITY_EN
   // Parity error flags travel with the read data they describe.
   always_comb begin
      a_perr_d = a_perr_q;
      b_perr_d = b_perr_q;
      if (busy_int) begin
         a_perr_d = 1'b0;
         b_perr_d = 1'b0;
      end else begin
         if (a_acc) begin
            a_perr_d = |(byte_par(a_rd) ^ a_rd_par);
         end
         if (b_acc) begin
            b_perr_d = |(byte_par(b_rd) ^ b_rd_par);
         end
      end
   end

   // Registered parity error flags.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         a_perr_q <= 1'b0;
         b_perr_q <= 1'b0;
      end else begin
         a_perr_q <= a_perr_d;
         b_perr_q <= b_perr_d;
      end
   end

   assign a_perr = a_perr_q;
   assign b_perr = b_perr_q;
`endif

endmodule
